// File: rtl/lector_secuencia_corte_pkg.sv
// Shared constants and types for the 512 x 12 cut-program memory.
// Used by the sequence reader and by the memory loader.
package lector_secuencia_corte_pkg;

  localparam int unsigned ANCHO_DIRECCION = 9;
  localparam int unsigned ANCHO_DATO      = 12;
  localparam int unsigned ANCHO_LATENCIA  = 2;
  localparam int unsigned ANCHO_PALABRAS  = 10;

  localparam logic [ANCHO_DATO-1:0]      MARCA_FIN     = 12'hFFF;
  localparam logic [ANCHO_DIRECCION-1:0] DIRECCION_MAX = 9'd511;
  localparam logic [ANCHO_PALABRAS-1:0]  PALABRAS_MAX  = 10'd1023;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2,
    FIN     = 2'd3
  } estado_t;

  function automatic logic es_direccion_final(input logic [ANCHO_DIRECCION-1:0] direccion);
    return direccion == DIRECCION_MAX;
  endfunction

endpackage

// File: rtl/contador_latencia_lectura.sv
// Read-latency down-counter: loads READ_LATENCY, decrements to zero, flags zero.
// Shared with the loader's read-back path.
module contador_latencia_lectura
  import lector_secuencia_corte_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_cargar,
  input  logic i_decrementar,
  output logic o_cero
);

  localparam logic [ANCHO_LATENCIA-1:0] CARGA = READ_LATENCY[ANCHO_LATENCIA-1:0];

  logic [ANCHO_LATENCIA-1:0] r_cuenta;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cuenta <= '0;
    end else if (i_cargar) begin
      r_cuenta <= CARGA;
    end else if (i_decrementar && (r_cuenta != '0)) begin
      r_cuenta <= r_cuenta - 1'b1;
    end
  end

  assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/lector_secuencia_corte.sv
// Read-side initiator for the cut-program memory: walks upward from a start
// address, hands words downstream until the 12'hFFF marker or an address wrap.
// Optional word counter output enabled by CONTADOR_PALABRAS_EN.
module lector_secuencia_corte
  import lector_secuencia_corte_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [ANCHO_DIRECCION-1:0] direccion_inicio,
  output logic                       leer_escribir_memoria,
  output logic [ANCHO_DIRECCION-1:0] direccion_memoria,
  input  logic [ANCHO_DATO-1:0]      dato_leer_memoria,
  input  logic                       corte_terminado,
  output logic [ANCHO_DATO-1:0]      dato_salida,
  output logic                       dato_valido,
  input  logic                       dato_aceptado,
  output logic                       ocupado,
  output logic                       terminado,
  output logic                       error_desborde
`ifdef CONTADOR_PALABRAS_EN
  ,
  output logic [ANCHO_PALABRAS-1:0]  palabras_leidas
`endif
);

  estado_t                    r_estado;
  logic [ANCHO_DIRECCION-1:0] r_direccion;
  logic [ANCHO_DATO-1:0]      r_dato;
  logic                       r_valido;
  logic                       r_ocupado;
  logic                       r_terminado;
  logic                       r_desborde;

  logic w_inicio;
  logic w_transferencia;
  logic w_cargar;
  logic w_decrementar;
  logic w_cero;

  assign w_inicio        = (r_estado == REPOSO) && iniciar;
  assign w_transferencia = (r_estado == ENTREGA) && r_valido && dato_aceptado;
  assign w_cargar        = w_inicio || (w_transferencia && !es_direccion_final(r_direccion));
  assign w_decrementar   = (r_estado == ESPERA) && !w_cero;

  contador_latencia_lectura #(
    .READ_LATENCY (READ_LATENCY)
  ) u_contador_latencia (
    .clock         (clock),
    .reset         (reset),
    .i_cargar      (w_cargar),
    .i_decrementar (w_decrementar),
    .o_cero        (w_cero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado    <= REPOSO;
      r_direccion <= '0;
      r_dato      <= '0;
      r_valido    <= 1'b0;
      r_ocupado   <= 1'b0;
      r_terminado <= 1'b0;
      r_desborde  <= 1'b0;
    end else begin
      r_terminado <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (iniciar) begin
            r_direccion <= direccion_inicio;
            r_desborde  <= 1'b0;
            r_ocupado   <= 1'b1;
            r_estado    <= ESPERA;
          end
        end
        ESPERA: begin
          // The end marker is consumed here and never reaches the cutter.
          if (w_cero) begin
            if (corte_terminado) begin
              r_terminado <= 1'b1;
              r_estado    <= FIN;
            end else begin
              r_dato   <= dato_leer_memoria;
              r_valido <= 1'b1;
              r_estado <= ENTREGA;
            end
          end
        end
        ENTREGA: begin
          if (w_transferencia) begin
            r_valido <= 1'b0;
            if (es_direccion_final(r_direccion)) begin
              r_desborde  <= 1'b1;
              r_direccion <= '0;
              r_terminado <= 1'b1;
              r_estado    <= FIN;
            end else begin
              r_direccion <= r_direccion + 1'b1;
              r_estado    <= ESPERA;
            end
          end
        end
        FIN: begin
          r_ocupado <= 1'b0;
          r_estado  <= REPOSO;
        end
        default: begin
          r_valido  <= 1'b0;
          r_ocupado <= 1'b0;
          r_estado  <= REPOSO;
        end
      endcase
    end
  end

  assign leer_escribir_memoria = 1'b0;
  assign direccion_memoria     = r_direccion;
  assign dato_salida           = r_dato;
  assign dato_valido           = r_valido;
  assign ocupado               = r_ocupado;
  assign terminado             = r_terminado;
  assign error_desborde        = r_desborde;

`ifdef CONTADOR_PALABRAS_EN
  logic [ANCHO_PALABRAS-1:0] r_palabras;

  // Holds after FIN so the count can be read until the next start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_palabras <= '0;
    end else if (w_inicio) begin
      r_palabras <= '0;
    end else if (w_transferencia && (r_palabras != PALABRAS_MAX)) begin
      r_palabras <= r_palabras + 1'b1;
    end
  end

  assign palabras_leidas = r_palabras;
`endif

endmodule

// File: tb/tb_lector_secuencia_corte.sv
// Self-checking bench for lector_secuencia_corte: behavioural RAM, a
// transaction-level reference model compared every cycle, and directed tests.
module tb_lector_secuencia_corte;

`ifdef CONTADOR_PALABRAS_EN
  localparam int RL = 2;
  localparam int P_PRIMERO = 3;
  localparam int P_PERIODO = 4;
  localparam int P_TERMINA = 11;
  localparam int P_MARCA   = 3;
`else
  localparam int RL = 1;
  localparam int P_PRIMERO = 2;
  localparam int P_PERIODO = 3;
  localparam int P_TERMINA = 8;
  localparam int P_MARCA   = 2;
`endif

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic [8:0]  direccion_inicio;
  logic        leer_escribir_memoria;
  logic [8:0]  direccion_memoria;
  logic [11:0] dato_leer_memoria;
  logic        corte_terminado;
  logic [11:0] dato_salida;
  logic        dato_valido;
  logic        dato_aceptado;
  logic        ocupado;
  logic        terminado;
  logic        error_desborde;
`ifdef CONTADOR_PALABRAS_EN
  logic [9:0]  palabras_leidas;
`endif

  lector_secuencia_corte #(.READ_LATENCY(RL)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .iniciar               (iniciar),
    .direccion_inicio      (direccion_inicio),
    .leer_escribir_memoria (leer_escribir_memoria),
    .direccion_memoria     (direccion_memoria),
    .dato_leer_memoria     (dato_leer_memoria),
    .corte_terminado       (corte_terminado),
    .dato_salida           (dato_salida),
    .dato_valido           (dato_valido),
    .dato_aceptado         (dato_aceptado),
    .ocupado               (ocupado),
    .terminado             (terminado),
    .error_desborde        (error_desborde)
`ifdef CONTADOR_PALABRAS_EN
    ,
    .palabras_leidas       (palabras_leidas)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nombre, $time, actual, esperado);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM with RL edges from address capture to valid data.
  logic [11:0] mem [0:511];
  logic [11:0] ram_pipe [0:RL-1];

  always @(posedge clock) begin
    ram_pipe[0] <= mem[direccion_memoria];
    for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  assign dato_leer_memoria = ram_pipe[RL-1];
  assign corte_terminado   = (dato_leer_memoria == 12'hFFF);

  // Reference model: on start, the whole program is read out of mem into a
  // queue; each word appears RL+1 cycles after the start or previous accept.
  logic        m_busy, m_valid, m_term, m_error;
  logic [8:0]  m_addr;
  int          m_wait;
  int          m_palabras;
  logic [11:0] m_words [$];

  initial begin
    m_busy = 0; m_valid = 0; m_term = 0; m_error = 0; m_addr = 0; m_wait = 0; m_palabras = 0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_busy = 0; m_valid = 0; m_term = 0; m_error = 0; m_addr = 0; m_wait = 0; m_palabras = 0;
        m_words.delete();
      end else if (m_term) begin
        m_term = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (iniciar) begin
          int a;
          m_words.delete();
          a = int'(direccion_inicio);
          for (int n = 0; n < 512; n++) begin
            if (mem[a] == 12'hFFF) break;
            m_words.push_back(mem[a]);
            if (a == 511) break;
            a++;
          end
          m_addr = direccion_inicio;
          m_error = 0;
          m_busy = 1;
          m_wait = RL + 1;
          m_palabras = 0;
        end
      end else if (m_valid) begin
        if (dato_aceptado) begin
          m_valid = 0;
          void'(m_words.pop_front());
          if (m_palabras < 1023) m_palabras++;
          if (m_addr == 9'd511) begin
            m_error = 1;
            m_addr = 0;
            m_term = 1;
          end else begin
            m_addr = m_addr + 9'd1;
            m_wait = RL + 1;
          end
        end
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_words.size() == 0) m_term = 1;
          else m_valid = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      check("dato_valido", dato_valido, m_valid);
      check("ocupado", ocupado, m_busy);
      check("terminado", terminado, m_term);
      check("error_desborde", error_desborde, m_error);
      check("direccion_memoria", direccion_memoria, m_addr);
      check("leer_escribir_memoria", leer_escribir_memoria, 1'b0);
      if (m_valid && m_words.size() > 0) check("dato_salida", dato_salida, m_words[0]);
`ifdef CONTADOR_PALABRAS_EN
      check("palabras_leidas", palabras_leidas, m_palabras);
`endif
    end
  end

  task automatic arrancar(input logic [8:0] dir, output int t0);
    @(negedge clock);
    iniciar = 1'b1;
    direccion_inicio = dir;
    @(negedge clock);
    iniciar = 1'b0;
    t0 = cyc;
  endtask

  task automatic observar(input int t0, output int n_val, output int c1, output int c2,
                          output logic [11:0] w1, output logic [11:0] w2, output int c_term);
    n_val = 0; c1 = -1; c2 = -1; w1 = '0; w2 = '0; c_term = -1;
    for (int k = 0; k < 60; k++) begin
      if (dato_valido) begin
        if (n_val == 0) begin c1 = cyc - t0; w1 = dato_salida; end
        else if (n_val == 1) begin c2 = cyc - t0; w2 = dato_salida; end
        n_val++;
      end
      if (terminado) begin
        c_term = cyc - t0;
        break;
      end
      @(negedge clock);
    end
    check("terminado_visto", c_term >= 0, 1'b1);
  endtask

  task automatic esperar_valido(input string nombre);
    int k = 0;
    while (k < 30 && !dato_valido) begin
      @(negedge clock);
      k++;
    end
    check(nombre, dato_valido, 1'b1);
  endtask

  task automatic esperar_terminado(input string nombre);
    int k = 0;
    while (k < 60 && !terminado) begin
      @(negedge clock);
      k++;
    end
    check(nombre, terminado, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n_val, c1, c2, c_term;
    logic [11:0] w1, w2;

    for (int i = 0; i < 512; i++) mem[i] = 12'h000;
    mem[10] = 12'h123; mem[11] = 12'h456; mem[12] = 12'hFFF;
    mem[200] = 12'hFFF;
    mem[510] = 12'h001; mem[511] = 12'h002;

    iniciar = 0; direccion_inicio = 0; dato_aceptado = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_direccion", direccion_memoria, 9'd0);
    check("reset_dato_salida", dato_salida, 12'h000);
    check("reset_valido", dato_valido, 1'b0);
    check("reset_ocupado", ocupado, 1'b0);
    check("reset_terminado", terminado, 1'b0);
    check("reset_desborde", error_desborde, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Program at 10 with downstream always ready.
    dato_aceptado = 1'b1;
    arrancar(9'd10, t0);
    observar(t0, n_val, c1, c2, w1, w2, c_term);
    check("t1_num_validos", n_val, 2);
    check("t1_palabra1", w1, 12'h123);
    check("t1_palabra2", w2, 12'h456);
    check("t1_latencia", c1, P_PRIMERO);
    check("t1_periodo", c2 - c1, P_PERIODO);
    check("t1_terminado", c_term, P_TERMINA);
`ifdef CONTADOR_PALABRAS_EN
    check("t1_palabras_leidas", palabras_leidas, 10'd2);
`endif
    @(negedge clock);
    check("t1_ocupado_final", ocupado, 1'b0);

    // Downstream stalls for five cycles on the first word.
    dato_aceptado = 1'b0;
    arrancar(9'd10, t0);
`ifdef CONTADOR_PALABRAS_EN
    check("t2_palabras_borradas", palabras_leidas, 10'd0);
`endif
    esperar_valido("t2_primer_valido");
    for (int k = 0; k < 5; k++) begin
      check("t2_valido_estable", dato_valido, 1'b1);
      check("t2_dato_estable", dato_salida, 12'h123);
      check("t2_direccion_estable", direccion_memoria, 9'd10);
      if (k < 4) @(negedge clock);
    end
    dato_aceptado = 1'b1;
    @(negedge clock);
    esperar_valido("t2_segundo_valido");
    check("t2_segunda_palabra", dato_salida, 12'h456);
    esperar_terminado("t2_terminado");

    // Marker at the start address: no data, terminado only.
    arrancar(9'd200, t0);
    observar(t0, n_val, c1, c2, w1, w2, c_term);
    check("t3_sin_validos", n_val, 0);
    check("t3_terminado", c_term, P_MARCA);
    check("t3_sin_desborde", error_desborde, 1'b0);

    // Wrap from 511 to 0 without a marker.
    arrancar(9'd510, t0);
    observar(t0, n_val, c1, c2, w1, w2, c_term);
    check("t4_num_validos", n_val, 2);
    check("t4_palabra1", w1, 12'h001);
    check("t4_palabra2", w2, 12'h002);
    check("t4_terminado_tras_acepta", c_term - c2, 1);
    check("t4_desborde", error_desborde, 1'b1);
    check("t4_direccion_cero", direccion_memoria, 9'd0);
    arrancar(9'd10, t0);
    check("t4_desborde_borrado", error_desborde, 1'b0);
    esperar_terminado("t4_terminado_reinicio");

    // Ignored start during ENTREGA, then asynchronous reset mid-cycle.
    dato_aceptado = 1'b0;
    arrancar(9'd10, t0);
    esperar_valido("t5_valido");
    iniciar = 1'b1;
    direccion_inicio = 9'd200;
    @(negedge clock);
    iniciar = 1'b0;
    check("t5_inicio_ignorado_dato", dato_salida, 12'h123);
    check("t5_inicio_ignorado_dir", direccion_memoria, 9'd10);
    #2 reset = 1'b0;
    #1;
    check("t5_reset_valido", dato_valido, 1'b0);
    check("t5_reset_ocupado", ocupado, 1'b0);
    check("t5_reset_direccion", direccion_memoria, 9'd0);
    check("t5_reset_terminado", terminado, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    dato_aceptado = 1'b1;
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
